mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin arbiter and sequencer that shares one sequential multiplier (controller plus datapath) between `NREQ` requesters. It captures the winning requester's operands, pulses the multiplier start, waits for the multiplier's done, then returns the product to the winner with a one-cycle done pulse. Every decision and data path carries a word-level sticky taint bit, consistent with the taint-tracking multiplier it fronts.

## Interface
Parameters:
- `WIDTH`, 4: operand width; product is `2*WIDTH`.
- `NREQ`, 2: number of requesters (2..8).

Ports:
- `clk` input 1: clock. One clock domain; all state updates on the rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `req` input NREQ: per-requester request, level; held until matching `done`.
- `req_t` input NREQ: taint of each `req` bit.
- `op_a` input NREQ*WIDTH: multiplicands. Requester i occupies bits [i*WIDTH +: WIDTH].
- `op_b` input NREQ*WIDTH: multipliers, packed the same way.
- `op_t` input NREQ: word taint of requester i's operand pair.
- `gnt` output NREQ: one-hot grant, held from LAUNCH through RESP.
- `done` output NREQ: one-cycle pulse to the served requester.
- `done_t` output NREQ: taint of `done`.
- `result` output 2*WIDTH: product, valid while `done` is high, held afterwards.
- `result_t` output 1: taint of `result`.
- `mult_start`, `mult_start_t` output 1 each: start to the multiplier control and its taint.
- `mult_a`, `mult_b` output WIDTH each: registered operands to the multiplier datapath.
- `mult_op_t` output 1: operand taint to the datapath.
- `mult_done`, `mult_done_t` input 1 each: multiplier productDone and its taint.
- `mult_product` input 2*WIDTH: multiplier product, sampled on `mult_done`.
- `mult_product_t` input 1: product taint.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP (2-bit encoding). Round-robin pointer `ptr`, range 0..NREQ-1.
- IDLE:
  - If any `req` is high, the winner is the first requester with `req` high, searching from `ptr` upward and wrapping.
  - Register the winner index, `mult_a`/`mult_b` = winner's operands, `mult_op_t` = `op_t[w]`. Go to LAUNCH.
  - With no request, stay in IDLE with all outputs 0.
- LAUNCH: `mult_start`=1 for exactly this cycle; `gnt[w]`=1. Go to WAIT.
- WAIT: hold `gnt` and operands. On `mult_done`=1, capture `mult_product` into `result` and go to RESP.
- RESP: `done[w]`=1 for one cycle. Set `ptr` = (w+1) mod NREQ. Go to IDLE.
- Requests are not aborted. If `req[w]` drops mid-operation, the operation still completes and `done[w]` still pulses. Losing requesters keep waiting.
- A `mult_done` seen outside WAIT is ignored.
- Taint (all sticky until `rst`):
  - `sel_t` is set at any IDLE arbitration where any `req_t` bit is high.
  - `mult_start_t` = `sel_t`.
  - `result_t` is set at capture to `mult_product_t | mult_done_t | sel_t | mult_op_t`.
  - `done_t[i]` = `done[i]`-cycle value `sel_t | mult_done_t`. It is also high whenever `sel_t` is set, because a tainted arbitration leaks through timing.
- Reset values: state IDLE, `ptr`=0, and every output and taint register 0, including `result` and `result_t`.
- Reset mid-operation returns to IDLE on the next edge. The multiplier must be reset in the same cycle by the top level.

## Timing
- Request seen in IDLE at edge 0: LAUNCH (`gnt`, `mult_start`) in cycle 1, WAIT from cycle 2.
- `mult_done` at cycle k leads to `done` at cycle k+1. Minimum IDLE-to-done overhead is 3 cycles plus multiplier latency.
- Back-to-back service: the next arbitration occurs in the IDLE cycle after RESP. This gives the multiplier one idle cycle to return to its START state before the next `mult_start`.
- Simultaneous `req` in IDLE: exactly one grant; lowest index at or after `ptr` wins.
- A `req` rising during RESP is first evaluated in the following IDLE cycle.

## Test plan
- Single request: `req`=01, A=3, B=5, stub multiplier returns done after 10 cycles → `gnt`=01 one cycle after req, `done`=01 one pulse, `result`=15, all taints 0.
- Contention and fairness: `req`=11 held continuously, NREQ=2 → grants alternate 01, 10, 01. Results are A0*B0 and A1*B1, e.g. 7*9=63 and 15*15=225.
- Wrap with NREQ=4, `ptr`=3: `req`=1001 → requester 3 served first, then requester 0.
- Taint: `req_t[1]`=1 during an arbitration → `mult_start_t`, `result_t` and `done_t` go to 1 and stay 1 until `rst`. With `op_t`=0 and all other taints 0, `result_t`=0 before that arbitration.
- Reset in WAIT: assert `rst` one cycle → state IDLE, `gnt`=0, `ptr`=0, `result`=0. A later `mult_done` pulse produces no `done`.
- Req dropped mid-WAIT: `req[0]` falls → `done[0]` still pulses and `result` is correct.

Source files
------------

// File: rtl/mult_share_if.sv
// Handshake bundle between the requesters, the shared-multiplier arbiter and the
// multiplier itself. Every data/control signal has a companion word-level taint bit.
interface mult_share_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_t;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       op_t;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       done_t;
  logic [2*WIDTH-1:0]    result;
  logic                  result_t;
  logic                  mult_start;
  logic                  mult_start_t;
  logic [WIDTH-1:0]      mult_a;
  logic [WIDTH-1:0]      mult_b;
  logic                  mult_op_t;
  logic                  mult_done;
  logic                  mult_done_t;
  logic [2*WIDTH-1:0]    mult_product;
  logic                  mult_product_t;

  // Requester/multiplier side of the bundle.
  modport master (
    output req, req_t, op_a, op_b, op_t,
    output mult_done, mult_done_t, mult_product, mult_product_t,
    input  gnt, done, done_t, result, result_t,
    input  mult_start, mult_start_t, mult_a, mult_b, mult_op_t
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req, req_t, op_a, op_b, op_t,
    input  mult_done, mult_done_t, mult_product, mult_product_t,
    output gnt, done, done_t, result, result_t,
    output mult_start, mult_start_t, mult_a, mult_b, mult_op_t
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among NREQ
// requesters, with sticky word-level taint on every decision and data path.
module mult_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic       clk,
  input  logic       rst,
  mult_share_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win;
  logic [PW-1:0]      win_nx;
  logic [NREQ-1:0]    gnt_r;
  logic [NREQ-1:0]    done_r;
  logic [NREQ-1:0]    done_t_r;
  logic [2*WIDTH-1:0] result_r;
  logic               result_t_r;
  logic               mult_start_r;
  logic [WIDTH-1:0]   mult_a_r;
  logic [WIDTH-1:0]   mult_b_r;
  logic               mult_op_t_r;
  logic               sel_t;

  // Scan from the pointer downward-in-priority so the lowest offset from ptr wins last.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    rr_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      if (r[PW'(j)]) rr_pick = PW'(j);
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb win_nx = rr_pick(bus.req, ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      win          <= '0;
      gnt_r        <= '0;
      done_r       <= '0;
      done_t_r     <= '0;
      result_r     <= '0;
      result_t_r   <= 1'b0;
      mult_start_r <= 1'b0;
      mult_a_r     <= '0;
      mult_b_r     <= '0;
      mult_op_t_r  <= 1'b0;
      sel_t        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt_r        <= '0;
          done_r       <= '0;
          mult_start_r <= 1'b0;
          if (|bus.req) begin
            win          <= win_nx;
            mult_a_r     <= bus.op_a[int'(win_nx)*WIDTH +: WIDTH];
            mult_b_r     <= bus.op_b[int'(win_nx)*WIDTH +: WIDTH];
            mult_op_t_r  <= bus.op_t[win_nx];
            sel_t        <= sel_t | (|bus.req_t);
            gnt_r        <= onehot(win_nx);
            mult_start_r <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          mult_start_r <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.mult_done) begin
            result_r   <= bus.mult_product;
            result_t_r <= result_t_r | bus.mult_product_t | bus.mult_done_t | sel_t | mult_op_t_r;
            done_r     <= onehot(win);
            done_t_r   <= done_t_r | (onehot(win) & {NREQ{sel_t | bus.mult_done_t}});
            state      <= RESP;
          end
        end
        RESP: begin
          done_r <= '0;
          gnt_r  <= '0;
          ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A tainted arbitration leaks through timing to every requester's done.
  assign bus.done_t       = done_t_r | {NREQ{sel_t}};
  assign bus.gnt          = gnt_r;
  assign bus.done         = done_r;
  assign bus.result       = result_r;
  assign bus.result_t     = result_t_r;
  assign bus.mult_start   = mult_start_r;
  assign bus.mult_start_t = sel_t;
  assign bus.mult_a       = mult_a_r;
  assign bus.mult_b       = mult_b_r;
  assign bus.mult_op_t    = mult_op_t_r;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NREQ=4) with a stub sequential multiplier.
module tb_mult_share_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
  mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int stub_lat = 3;
  bit stub_en  = 1'b1;
  bit force_done = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [3:0]  gnt;
    logic [7:0]  res;
    int          gnt_lat;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      lat++;
      if (bus.gnt != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (bus.done != '0) ok = 1'b1;
    end
  endtask

  // Stub multiplier: reacts just after each rising edge, returns a*b after stub_lat cycles.
  initial begin : stub
    int cnt;
    cnt = 0;
    bus.mult_done      = 1'b0;
    bus.mult_done_t    = 1'b0;
    bus.mult_product   = '0;
    bus.mult_product_t = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.mult_done = 1'b0;
      if (force_done) begin
        bus.mult_done    = 1'b1;
        bus.mult_product = 8'hAB;
      end else if (rst) begin
        cnt = 0;
      end else if (stub_en && bus.mult_start) begin
        cnt = stub_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mult_done    = 1'b1;
          bus.mult_product = 8'(bus.mult_a) * 8'(bus.mult_b);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit ok;
    bit seen;

    tbl[0] = '{4'b0001, 16'h0003, 16'h0005, 10, 4'b0001, 8'd15,  1};
    tbl[1] = '{4'b0011, 16'h00F7, 16'h00F9, 3,  4'b0010, 8'd225, 2};
    tbl[2] = '{4'b0011, 16'h00F7, 16'h00F9, 3,  4'b0001, 8'd63,  2};
    tbl[3] = '{4'b0011, 16'h00F7, 16'h00F9, 3,  4'b0010, 8'd225, 2};
    tbl[4] = '{4'b0100, 16'h0400, 16'h0B00, 4,  4'b0100, 8'd44,  2};
    tbl[5] = '{4'b1001, 16'hC002, 16'hA00D, 3,  4'b1000, 8'd120, 2};
    tbl[6] = '{4'b1001, 16'hC002, 16'hA00D, 5,  4'b0001, 8'd26,  2};

    rst = 1'b1;
    bus.req = '0; bus.req_t = '0; bus.op_a = '0; bus.op_b = '0; bus.op_t = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",      32'(bus.gnt), 32'h0);
    chk("rst_done",     32'(bus.done), 32'h0);
    chk("rst_result",   32'({bus.result_t, bus.result}), 32'h0);
    chk("rst_start",    32'({bus.mult_start, bus.mult_start_t}), 32'h0);
    chk("rst_done_t",   32'(bus.done_t), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table: single request, contention/fairness, and pointer wrap at requester 3.
    for (int i = 0; i < 7; i++) begin
      bus.req  = tbl[i].req;
      bus.op_a = tbl[i].a;
      bus.op_b = tbl[i].b;
      stub_lat = tbl[i].lat;
      wait_gnt(lat, ok);
      chk($sformatf("v%0d_gnt_seen", i), 32'(ok), 32'h1);
      chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_gnt_lat", i), 32'(lat), 32'(tbl[i].gnt_lat));
      chk($sformatf("v%0d_start", i), 32'({bus.mult_start, bus.mult_start_t}), 32'h2);
      @(negedge clk);
      chk($sformatf("v%0d_start_drop", i), 32'({bus.mult_start, bus.gnt}), 32'(tbl[i].gnt));
      wait_done(ok);
      chk($sformatf("v%0d_done_seen", i), 32'(ok), 32'h1);
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(tbl[i].res));
      chk($sformatf("v%0d_taints", i), 32'({bus.result_t, bus.done_t}), 32'h0);
    end
    bus.req = '0;
    @(negedge clk);
    chk("done_one_cycle", 32'({bus.done, bus.gnt}), 32'h0);

    // Requester 0 drops its request in WAIT: the operation still completes.
    bus.op_a = 16'h0006; bus.op_b = 16'h0007; stub_lat = 6;
    bus.req = 4'b0001;
    wait_gnt(lat, ok);
    chk("drop_gnt", 32'(bus.gnt), 32'h1);
    repeat (2) @(negedge clk);
    bus.req = '0;
    wait_done(ok);
    chk("drop_done", 32'(bus.done), 32'h1);
    chk("drop_result", 32'(bus.result), 32'd42);

    // Tainted arbitration on requester 1; taints must stick afterwards.
    bus.op_a = 16'h0050; bus.op_b = 16'h0050; stub_lat = 3;
    bus.req = 4'b0010; bus.req_t = 4'b0010;
    wait_gnt(lat, ok);
    chk("taint_gnt", 32'(bus.gnt), 32'h2);
    chk("taint_start_t", 32'(bus.mult_start_t), 32'h1);
    chk("taint_done_t_early", 32'(bus.done_t), 32'hF);
    wait_done(ok);
    chk("taint_result", 32'(bus.result), 32'd25);
    chk("taint_result_t", 32'(bus.result_t), 32'h1);
    chk("taint_done_t", 32'(bus.done_t), 32'hF);
    bus.req = '0; bus.req_t = '0;
    repeat (3) @(negedge clk);
    chk("taint_sticky", 32'({bus.result_t, bus.mult_start_t, bus.done_t}), 32'h3F);

    // Reset while waiting on the multiplier, then a stray mult_done in IDLE.
    stub_en = 1'b0;
    bus.op_a = 16'h0009; bus.op_b = 16'h0009;
    bus.req = 4'b0001;
    wait_gnt(lat, ok);
    chk("rstw_gnt", 32'(bus.gnt), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_gnt_clr", 32'(bus.gnt), 32'h0);
    chk("rstw_result", 32'(bus.result), 32'h0);
    chk("rstw_taints", 32'({bus.result_t, bus.mult_start_t, bus.done_t}), 32'h0);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    chk("rstw_stray_done", 32'(seen), 32'h0);
    chk("rstw_stray_result", 32'(bus.result), 32'h0);

    // Pointer must be back at 0: requester 1 beats requester 2.
    stub_en = 1'b1; stub_lat = 2;
    bus.op_a = 16'h0230; bus.op_b = 16'h0230;
    bus.req = 4'b0110;
    wait_gnt(lat, ok);
    chk("ptr_reset_gnt", 32'(bus.gnt), 32'h2);
    wait_done(ok);
    chk("ptr_reset_result", 32'(bus.result), 32'd9);
    bus.req = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
